nv_ram_fifo_ctrl_160x514: RTL and testbench

//  Sequences one nv_ram_rwsp_160x514 (registered read address, ore-gated output register) as a 514-bit valid/ready FIFO.

---
 rtl/nv_ram_fifo_ctrl_160x514.sv | 109 ++++++++++
 tb/tb_nv_ram_fifo_ctrl_160x514.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/nv_ram_fifo_ctrl_160x514.sv
// Valid/ready FIFO controller around a 2-cycle-latency RAM with a 3-entry output skid.
// Owns RAM pointers/occupancy and hides the read latency so a ready consumer sees 1 word/cycle.
module nv_ram_fifo_ctrl_160x514 #(
    parameter int DEPTH = 160,
    parameter int WIDTH = 514,
    parameter int AW    = 8,
    parameter int SKID  = 3
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             wr_pvld,
    output logic             wr_prdy,
    input  logic [WIDTH-1:0] wr_pd,
    output logic             rd_pvld,
    input  logic             rd_prdy,
    output logic [WIDTH-1:0] rd_pd,
    output logic             ram_we,
    output logic [AW-1:0]    ram_wa,
    output logic [WIDTH-1:0] ram_di,
    output logic             ram_re,
    output logic [AW-1:0]    ram_ra,
    output logic             ram_ore,
    input  logic [WIDTH-1:0] ram_dout,
    input  logic [31:0]      pwrbus_ram_pd_in,
    output logic [31:0]      pwrbus_ram_pd,
    output logic [AW-1:0]    ram_cnt
);
    localparam int SCW = $clog2(SKID + 1);
    localparam int CRW = SCW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [1:0]       vld_pipe_q;
    logic [SCW-1:0]   skid_cnt_q, skid_cnt_d;
    logic [WIDTH-1:0] skid_q [SKID];
    logic [WIDTH-1:0] skid_d [SKID];
    logic             wr_acc, issue, pop, push;
    logic [CRW-1:0]   credit_used;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign pwrbus_ram_pd = pwrbus_ram_pd_in;

    assign wr_prdy = (cnt_q != AW'(DEPTH));
    assign wr_acc  = wr_pvld & wr_prdy;
    assign ram_we  = wr_acc;
    assign ram_wa  = wr_ptr_q;
    assign ram_di  = wr_pd;

    assign rd_pvld = (skid_cnt_q != '0);
    assign rd_pd   = skid_q[0];
    assign pop     = rd_pvld & rd_prdy;
    // vld_pipe_q[0]: output-register stage, vld_pipe_q[1]: data landing into skid
    assign push    = vld_pipe_q[1];

    // A same-cycle pop returns its slot, otherwise each word would hold a credit
    // for four cycles and a ready consumer would only see 3 words per 4 cycles.
    assign credit_used = CRW'(skid_cnt_q) + CRW'(vld_pipe_q[0]) + CRW'(vld_pipe_q[1]);
    assign issue       = (cnt_q != '0) && (credit_used < CRW'(SKID) + CRW'(pop));

    assign ram_re  = issue;
    assign ram_ra  = rd_ptr_q;
    assign ram_ore = vld_pipe_q[0];
    assign ram_cnt = cnt_q;

    always_comb begin
        wr_ptr_d = wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = issue  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q + AW'(wr_acc) - AW'(issue);
    end

    always_comb begin
        skid_d     = skid_q;
        skid_cnt_d = skid_cnt_q;
        if (pop) begin
            for (int i = 0; i < SKID - 1; i++) skid_d[i] = skid_q[i + 1];
            skid_cnt_d = skid_cnt_q - SCW'(1);
        end
        if (push) begin
            skid_d[skid_cnt_d] = ram_dout;
            skid_cnt_d         = skid_cnt_d + SCW'(1);
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            vld_pipe_q <= '0;
            skid_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            vld_pipe_q <= {vld_pipe_q[0], issue};
            skid_cnt_q <= skid_cnt_d;
        end
    end

    // Payload storage needs no reset; skid_cnt_q qualifies it.
    always_ff @(posedge nvdla_core_clk) begin
        skid_q <= skid_d;
    end

endmodule

// File: tb/tb_nv_ram_fifo_ctrl_160x514.sv
// Bench for nv_ram_fifo_ctrl_160x514: behavioural RAM, queue scoreboard, directed and random traffic.
module tb_nv_ram_fifo_ctrl_160x514;
    localparam int W = 514, DEPTH = 160, AW = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          wr_pvld = 1'b0, rd_prdy = 1'b0;
    logic [W-1:0]  wr_pd = '0;
    logic          wr_prdy, rd_pvld, ram_we, ram_re, ram_ore;
    logic [W-1:0]  rd_pd, ram_di, ram_dout;
    logic [AW-1:0] ram_wa, ram_ra, ram_cnt;
    logic [31:0]   pwr_in = '0, pwr_out;

    nv_ram_fifo_ctrl_160x514 dut (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
        .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
        .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
        .ram_we(ram_we), .ram_wa(ram_wa), .ram_di(ram_di),
        .ram_re(ram_re), .ram_ra(ram_ra), .ram_ore(ram_ore), .ram_dout(ram_dout),
        .pwrbus_ram_pd_in(pwr_in), .pwrbus_ram_pd(pwr_out), .ram_cnt(ram_cnt)
    );

    always #5 clk = ~clk;

    // RAM: registered read address, output register loaded on ore
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] ra_l;
    logic [W-1:0]  dout_r;
    always @(posedge clk) begin
        if (ram_we)  mem[ram_wa] <= ram_di;
        if (ram_re)  ra_l <= ram_ra;
        if (ram_ore) dout_r <= mem[ra_l];
    end
    assign ram_dout = dout_r;

    int checks = 0, errors = 0;
    int n_wr = 0, n_re = 0, n_pop = 0;
    logic [W-1:0] q [$];
    logic s_acc, s_pop, s_re, s_ore, s_pvld, s_wprdy;
    logic [AW-1:0] s_cnt, s_wa, s_ra;
    logic [W-1:0] s_pd, prev_pd;
    logic prev_re = 1'b0, prev_stall = 1'b0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] w = '0;
        for (int i = 0; i < 17; i++) w = {w[W-33:0], $urandom()};
        return w;
    endfunction

    task automatic model_reset();
        q.delete();
        n_wr = 0; n_re = 0; n_pop = 0;
        prev_re = 1'b0; prev_stall = 1'b0;
    endtask

    // One clock: sample and check at negedge, then release to just after posedge.
    task automatic tick();
        @(negedge clk);
        s_acc = wr_pvld & wr_prdy; s_pop = rd_pvld & rd_prdy;
        s_re = ram_re; s_ore = ram_ore; s_pvld = rd_pvld; s_wprdy = wr_prdy;
        s_cnt = ram_cnt; s_wa = ram_wa; s_ra = ram_ra; s_pd = rd_pd;
        chk("ram_cnt", W'(ram_cnt), W'(n_wr - n_re));
        chk("wr_prdy", W'(wr_prdy), W'((n_wr - n_re) != DEPTH));
        chk("credit", W'((n_re - n_pop) <= 3), W'(1));
        if (ram_ore) chk("ore_after_re", W'(prev_re), W'(1));
        if (prev_stall) begin
            chk("stall_vld", W'(rd_pvld), W'(1));
            chk("stall_pd", rd_pd, prev_pd);
        end
        if (ram_re) begin
            chk("re_nonempty", W'((n_wr - n_re) > 0), W'(1));
            chk("ram_ra", W'(ram_ra), W'(n_re % DEPTH));
            n_re++;
        end
        if (s_pop) begin
            if (q.size() == 0) chk("sb_nonempty", W'(q.size()), W'(1));
            else chk("rd_pd", rd_pd, q.pop_front());
            n_pop++;
        end
        if (s_acc) begin
            chk("ram_wa", W'(ram_wa), W'(n_wr % DEPTH));
            chk("ram_di", ram_di, wr_pd);
            q.push_back(wr_pd);
            n_wr++;
        end
        prev_re = ram_re; prev_stall = rd_pvld & ~rd_prdy; prev_pd = rd_pd;
        @(posedge clk); #1;
    endtask

    task automatic drain();
        wr_pvld = 1'b0; rd_prdy = 1'b1;
        for (int k = 0; k < 400 && q.size() != 0; k++) tick();
        chk("drain_empty", W'(q.size()), W'(0));
        tick();
        chk("drain_vld", W'(s_pvld), W'(0));
    endtask

    initial begin
        int acc, got, words;
        // reset state
        pwr_in = 32'hA5C3_0F17;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cnt", W'(ram_cnt), W'(0));
        chk("rst_wprdy", W'(wr_prdy), W'(1));
        chk("rst_rvld", W'(rd_pvld), W'(0));
        chk("rst_strobes", W'({ram_we, ram_re, ram_ore}), W'(0));
        chk("pwrbus_rst", W'(pwr_out), W'(32'hA5C3_0F17));
        rstn = 1'b1;

        // first-word latency
        rd_prdy = 1'b1; wr_pvld = 1'b1; wr_pd = W'(16'h155);
        tick(); chk("lat_re0", W'(s_re), W'(0));
        wr_pvld = 1'b0;
        tick(); chk("lat_re1", W'(s_re), W'(1)); chk("lat_ra1", W'(s_ra), W'(0));
        tick(); chk("lat_ore2", W'(s_ore), W'(1));
        tick(); chk("lat_vld3", W'(s_pvld), W'(0));
        tick(); chk("lat_vld4", W'(s_pvld), W'(1)); chk("lat_pd4", s_pd, W'(16'h155));
        tick(); chk("lat_vld5", W'(s_pvld), W'(0));

        // streaming, no bubbles once filled
        for (int i = 0; i < 400; i++) begin
            wr_pvld = 1'b1; rd_prdy = 1'b1; wr_pd = W'(1000 + i);
            tick();
            if (i >= 4) begin
                chk("stream_rvld", W'(s_pvld), W'(1));
                chk("stream_wprdy", W'(s_wprdy), W'(1));
            end
        end
        drain();

        // full: RAM 160 + skid 3
        rd_prdy = 1'b0; acc = 0;
        for (int k = 0; k < 170; k++) begin
            wr_pvld = 1'b1; wr_pd = W'(5000 + acc);
            tick();
            if (s_acc) acc++;
        end
        chk("full_accepted", W'(acc), W'(163));
        chk("full_cnt", W'(s_cnt), W'(DEPTH));
        chk("full_wprdy", W'(s_wprdy), W'(0));
        wr_pvld = 1'b0; rd_prdy = 1'b1;
        tick();
        rd_prdy = 1'b0; got = 0;
        for (int k = 0; k < 2; k++) begin
            tick();
            if (s_wprdy) got = 1;
        end
        chk("full_reopen", W'(got), W'(1));
        drain();

        // simultaneous write accept and read issue
        rd_prdy = 1'b0; wr_pvld = 1'b1; wr_pd = rnd_word();
        tick(); chk("sim_no_re_empty", W'(s_re), W'(0));
        wr_pd = rnd_word();
        tick();
        chk("sim_re_next", W'(s_re), W'(1));
        chk("sim_acc", W'(s_acc), W'(1));
        chk("sim_cnt_before", W'(s_cnt), W'(1));
        wr_pvld = 1'b0;
        tick(); chk("sim_cnt_stays", W'(s_cnt), W'(1)); chk("sim_re2", W'(s_re), W'(1));
        tick(); chk("sim_cnt_zero", W'(s_cnt), W'(0));
        drain();

        // randomized backpressure
        words = 0; wr_pd = rnd_word();
        for (int c = 0; c < 40000 && words < 10000; c++) begin
            wr_pvld = ($urandom_range(0, 9) < 7);
            rd_prdy = $urandom_range(0, 1) == 1;
            tick();
            if (s_acc) begin
                words++;
                wr_pd = rnd_word();
            end
        end
        chk("rand_words", W'(words), W'(10000));
        drain();

        // asynchronous reset mid-stream
        rd_prdy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            wr_pvld = 1'b1; wr_pd = rnd_word();
            tick();
        end
        #2;
        rstn = 1'b0; wr_pvld = 1'b0; pwr_in = 32'h1234_5678;
        #1;
        chk("mid_rst_cnt", W'(ram_cnt), W'(0));
        chk("mid_rst_rvld", W'(rd_pvld), W'(0));
        chk("mid_rst_wprdy", W'(wr_prdy), W'(1));
        chk("mid_rst_strobes", W'({ram_we, ram_re, ram_ore}), W'(0));
        chk("pwrbus_mid", W'(pwr_out), W'(32'h1234_5678));
        model_reset();
        @(posedge clk); #1;
        rstn = 1'b1;
        wr_pvld = 1'b1; wr_pd = rnd_word();
        tick(); chk("post_rst_wa", W'(s_wa), W'(0));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
